// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings and bit-timing constants.
package uart_pkg;

   // Simulation bit period and the 50 MHz / 9600 baud synthesis value.
   localparam int CLKS_PER_BIT_DEF      = 10;
   localparam int CLKS_PER_BIT_50M_9600 = 5208;

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_START = 4'b0010,
      S_DATA  = 4'b0100,
      S_STOP  = 4'b1000
   } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial input and received-byte outputs of the UART receiver.
interface uart_rx_if;
   logic       rx_i;
   logic [7:0] data_o;
   logic       rx_done_o;
   logic       frame_err_o;
   logic       busy_o;

   modport master (
      output rx_i,
      input  data_o, rx_done_o, frame_err_o, busy_o
   );

   modport slave (
      input  rx_i,
      output data_o, rx_done_o, frame_err_o, busy_o
   );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments make meta and q shift as a pipeline;
   // blocking ones would collapse both flops into one.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, stop-bit check.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
   input logic      clk,
   input logic      rst,
   uart_rx_if.slave bus
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

   rx_state_t   state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [7:0]  shreg, shreg_nxt;
   logic [7:0]  data, data_nxt;
   logic        done, done_nxt;
   logic        ferr, ferr_nxt;
   logic        need_high, need_high_nxt;
   logic        rx_s;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rx_i),
      .q   (rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data      <= '0;
         done      <= 1'b0;
         ferr      <= 1'b0;
         need_high <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shreg     <= shreg_nxt;
         data      <= data_nxt;
         done      <= done_nxt;
         ferr      <= ferr_nxt;
         need_high <= need_high_nxt;
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = (cnt == BIT_LAST) ? '0 : cnt + 16'd1;
      idx_nxt       = idx;
      shreg_nxt     = shreg;
      data_nxt      = data;
      done_nxt      = 1'b0;
      ferr_nxt      = 1'b0;
      need_high_nxt = need_high;

      unique case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            idx_nxt = '0;
            // After a framing error the line must be seen high before a new start.
            if (rx_s)
               need_high_nxt = 1'b0;
            else if (!need_high)
               state_nxt = S_START;
         end
         S_START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt   = '0;
               state_nxt = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt == BIT_LAST) begin
               shreg_nxt[idx] = rx_s;
               idx_nxt        = idx + 3'd1;
               if (idx == 3'd7)
                  state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            // Return to IDLE at the stop sample so back-to-back frames are caught.
            if (cnt == BIT_LAST) begin
               state_nxt = S_IDLE;
               if (rx_s) begin
                  data_nxt = shreg;
                  done_nxt = 1'b1;
               end else begin
                  ferr_nxt      = 1'b1;
                  need_high_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.data_o      = data;
   assign bus.rx_done_o   = done;
   assign bus.frame_err_o = ferr;
   assign bus.busy_o      = (state != S_IDLE);

endmodule
